// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty decoder.
//   DUTY_STEPS : number of duty steps on the generator's scale (0..DUTY_STEPS)
//   DUTY_W     : width of the decoded duty value
//   pwm_state_e: measurement FSM states
package pwm_pkg;

  localparam int DUTY_STEPS = 10;
  localparam int DUTY_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_edge_cond.sv
// Input conditioning for an asynchronous PWM pin: 2-flop synchronizer,
// optional glitch filter, and single-cycle rise/fall pulses.
// Build option: define PWM_GLITCH_FILTER_EN to insert a glitch filter that
// only follows the synchronized level after it has been stable at a new
// value for FILT_LEN consecutive cycles.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   raw   : asynchronous PWM input
//   level : conditioned level
//   rise  : one-cycle pulse on a 0->1 change of level
//   fall  : one-cycle pulse on a 1->0 change of level
module pwm_edge_cond #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  if (FILT_LEN < 1) begin : g_bad_filt_len
    $error("pwm_edge_cond: FILT_LEN must be at least 1");
  end

  logic sync1;
  logic sync2;
  logic lvl_q;
  logic lvl_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

`ifdef PWM_GLITCH_FILTER_EN
  localparam int FC_W = $clog2(FILT_LEN + 1);

  // Counts consecutive cycles where the synchronized input disagrees with
  // the filtered level; any agreement restarts the count.
  logic [FC_W-1:0] diff_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lvl_q    <= 1'b0;
      diff_cnt <= '0;
    end else if (sync2 != lvl_q) begin
      if (diff_cnt == FC_W'(FILT_LEN - 1)) begin
        lvl_q    <= sync2;
        diff_cnt <= '0;
      end else begin
        diff_cnt <= diff_cnt + FC_W'(1);
      end
    end else begin
      diff_cnt <= '0;
    end
  end
`else
  assign lvl_q = sync2;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lvl_d <= 1'b0;
    end else begin
      lvl_d <= lvl_q;
    end
  end

  assign level = lvl_q;
  assign rise  = lvl_q & ~lvl_d;
  assign fall  = ~lvl_q & lvl_d;

endmodule

// File: rtl/pwm_duty_decoder.sv
// PWM duty decoder: measures high time and period (rise to rise) of an
// asynchronous PWM input in clk cycles and converts each measurement to the
// 0..10 duty scale of the matching generator. A constant input is reported
// through a timeout as 0% or 100% duty.
// Build option: PWM_GLITCH_FILTER_EN enables the input glitch filter inside
// pwm_edge_cond (FILT_LEN stable samples).
// Ports:
//   clk        : system clock
//   rst_n      : synchronous active-low reset
//   pwm_in     : asynchronous PWM input
//   high_cnt   : high time of the last completed period
//   period_cnt : length of the last completed period
//   duty_level : decoded duty, 0..10
//   meas_valid : one-cycle pulse when the outputs update
//   stuck      : high while no edge has been seen for TIMEOUT cycles
module pwm_duty_decoder
  import pwm_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 1000,
  parameter int FILT_LEN = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  high_cnt,
  output logic [CNT_W-1:0]  period_cnt,
  output logic [DUTY_W-1:0] duty_level,
  output logic              meas_valid,
  output logic              stuck
);

  if (TIMEOUT < 2 || longint'(TIMEOUT) >= (64'(1) << CNT_W)) begin : g_bad_timeout
    $error("pwm_duty_decoder: TIMEOUT must satisfy 2 <= TIMEOUT < 2**CNT_W");
  end

  // Products of a count with constants up to 20 fit in CNT_W+5 bits.
  localparam int PW = CNT_W + 5;
  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

  logic level;
  logic rise;
  logic fall;

  pwm_edge_cond #(
    .FILT_LEN (FILT_LEN)
  ) u_edge_cond (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (pwm_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  pwm_state_e       state_q;
  logic [CNT_W-1:0] hi_q;
  logic [CNT_W-1:0] per_q;
  logic [CNT_W-1:0] idle_q;

  logic              edge_seen;
  logic              timeout_hit;
  logic [PW-1:0]     hi20;
  logic [DUTY_W-1:0] duty_next;

  assign edge_seen   = rise | fall;
  // An edge in the same cycle pre-empts the timeout.
  assign timeout_hit = !edge_seen && (idle_q == TO - CNT_W'(1));

  // Rounded duty = largest k with 20*hi >= (2k-1)*per; ties round up.
  always_comb begin
    hi20      = (PW'(hi_q) << 4) + (PW'(hi_q) << 2);
    duty_next = '0;
    for (int k = 1; k <= DUTY_STEPS; k++) begin
      if (hi20 >= PW'(per_q) * PW'(2 * k - 1)) begin
        duty_next = DUTY_W'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hi_q       <= '0;
      per_q      <= '0;
      idle_q     <= '0;
      high_cnt   <= '0;
      period_cnt <= '0;
      duty_level <= '0;
      meas_valid <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      meas_valid <= 1'b0;

      if (edge_seen) begin
        idle_q <= '0;
        stuck  <= 1'b0;
      end else if (idle_q != TO) begin
        idle_q <= idle_q + CNT_W'(1);
      end

      if (timeout_hit) begin
        stuck      <= 1'b1;
        state_q    <= IDLE;
        high_cnt   <= '0;
        period_cnt <= '0;
        duty_level <= level ? DUTY_W'(DUTY_STEPS) : '0;
        meas_valid <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (rise) begin
              hi_q    <= CNT_W'(1);
              per_q   <= CNT_W'(1);
              state_q <= HIGH;
            end
          end
          HIGH: begin
            per_q <= per_q + CNT_W'(1);
            if (fall) begin
              state_q <= LOW;
            end else begin
              hi_q <= hi_q + CNT_W'(1);
            end
          end
          LOW: begin
            if (rise) begin
              high_cnt   <= hi_q;
              period_cnt <= per_q;
              duty_level <= duty_next;
              meas_valid <= 1'b1;
              hi_q       <= CNT_W'(1);
              per_q      <= CNT_W'(1);
              state_q    <= HIGH;
            end else begin
              per_q <= per_q + CNT_W'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Self-checking bench for pwm_duty_decoder. A timestamp-based model derives
// every expected output from the conditioned input's edge times; a compare
// process checks all outputs each cycle, and directed scenarios pin the
// model with hand-computed values.
module tb_pwm_duty_decoder;

  localparam int CNT_W    = 16;
  localparam int TIMEOUT  = 60;
  localparam int FILT_LEN = 3;

  logic             clk;
  logic             rst_n;
  logic             pwm_in;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic [3:0]       duty_level;
  logic             meas_valid;
  logic             stuck;

  pwm_duty_decoder #(
    .CNT_W    (CNT_W),
    .TIMEOUT  (TIMEOUT),
    .FILT_LEN (FILT_LEN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .duty_level (duty_level),
    .meas_valid (meas_valid),
    .stuck      (stuck)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int pulse_cnt = 0;
  int min_per   = 1 << 30;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Conditioned level = pwm_in seen two clocks late (cleared by reset).
  // Measurements come from edge timestamps: hi = fall - rise, per = rise - rise.
  int  k = 0;
  int  te = 0;
  int  t_rise = 0;
  int  t_fall = 0;
  bit  armed = 0;
  bit  started = 0;
  bit  d1 = 0, d2 = 0, d3 = 0;
  int  e_hi = 0, e_per = 0, e_duty = 0;
  bit  e_valid = 0, e_stuck = 0;
`ifdef PWM_GLITCH_FILTER_EN
  bit  fl = 0, flp = 0;
  int  frun = 0;
`endif

  always @(posedge clk) begin
    bit lvl, prv;
    k++;
    if (!rst_n) begin
      d1 = 0; d2 = 0; d3 = 0;
`ifdef PWM_GLITCH_FILTER_EN
      fl = 0; flp = 0; frun = 0;
`endif
      armed = 0; te = k;
      e_hi = 0; e_per = 0; e_duty = 0; e_valid = 0; e_stuck = 0;
      started = 1;
    end else begin
`ifdef PWM_GLITCH_FILTER_EN
      lvl = fl; prv = flp;
`else
      lvl = d2; prv = d3;
`endif
      e_valid = 0;
      if (lvl && !prv) begin
        if (armed) begin
          e_hi    = t_fall - t_rise;
          e_per   = k - t_rise;
          e_duty  = (20 * e_hi + e_per) / (2 * e_per);
          e_valid = 1;
        end
        armed = 1; t_rise = k; te = k; e_stuck = 0;
      end else if (!lvl && prv) begin
        t_fall = k; te = k; e_stuck = 0;
      end else if (k - te == TIMEOUT) begin
        e_stuck = 1; armed = 0;
        e_hi = 0; e_per = 0; e_duty = lvl ? 10 : 0; e_valid = 1;
      end
`ifdef PWM_GLITCH_FILTER_EN
      flp = fl;
      if (d2 != fl) begin
        frun++;
        if (frun == FILT_LEN) begin fl = d2; frun = 0; end
      end else begin
        frun = 0;
      end
`endif
      d3 = d2; d2 = d1; d1 = pwm_in;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("meas_valid", int'(meas_valid), int'(e_valid));
      chk("stuck", int'(stuck), int'(e_stuck));
      chk("high_cnt", int'(high_cnt), e_hi);
      chk("period_cnt", int'(period_cnt), e_per);
      chk("duty_level", int'(duty_level), e_duty);
      if (meas_valid) begin
        pulse_cnt++;
        if (int'(period_cnt) < min_per) min_per = int'(period_cnt);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int hi, input int per, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int c = 0; c < per; c++) begin
        @(negedge clk);
        pwm_in = (c < hi);
      end
    end
  endtask

  task automatic hold(input bit v, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      pwm_in = v;
    end
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p0;
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset high_cnt", int'(high_cnt), 0);
    chk("reset duty_level", int'(duty_level), 0);
    chk("reset stuck", int'(stuck), 0);

    // 1: steady 5/10
    p0 = pulse_cnt;
    drive(5, 10, 6);
    settle();
    chk("t1 pulses", pulse_cnt - p0, 5);
    chk("t1 high_cnt", int'(high_cnt), 5);
    chk("t1 period_cnt", int'(period_cnt), 10);
    chk("t1 duty", int'(duty_level), 5);

    // 2: duty 3 -> 7
    drive(3, 10, 4);
    drive(7, 10, 3);
    settle();
    chk("t2 high_cnt", int'(high_cnt), 7);
    chk("t2 duty", int'(duty_level), 7);

    // 3: rounding
    drive(1, 4, 4);
    settle();
`ifndef PWM_GLITCH_FILTER_EN
    chk("t3 period 4", int'(period_cnt), 4);
    chk("t3 duty 1/4", int'(duty_level), 3);
`endif
    drive(1, 3, 4);
    settle();
`ifndef PWM_GLITCH_FILTER_EN
    chk("t3 duty 1/3", int'(duty_level), 3);
`endif

    // 4: stuck low, stuck high, recovery
    hold(1'b0, 5);
    #1;
    p0 = pulse_cnt;
    hold(1'b0, TIMEOUT + 5);
    #1;
    chk("t4 stuck0", int'(stuck), 1);
    chk("t4 duty0", int'(duty_level), 0);
    chk("t4 period0", int'(period_cnt), 0);
    chk("t4 pulses0", pulse_cnt - p0, 1);
    hold(1'b1, TIMEOUT + 10);
    #1;
    chk("t4 stuck1", int'(stuck), 1);
    chk("t4 duty1", int'(duty_level), 10);
    hold(1'b0, 5);
    #1;
    chk("t4 cleared", int'(stuck), 0);

    // 5: reset while high
    drive(5, 10, 3);
    hold(1'b1, 3);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t5 high_cnt", int'(high_cnt), 0);
    chk("t5 period_cnt", int'(period_cnt), 0);
    chk("t5 duty", int'(duty_level), 0);
    chk("t5 meas_valid", int'(meas_valid), 0);
    p0 = pulse_cnt;
    hold(1'b1, 8);
    #1;
    chk("t5 no early pulse", pulse_cnt - p0, 0);
    drive(5, 10, 3);

    // 6: 2-cycle glitch inside a low phase
    drive(5, 10, 2);
    min_per = 1 << 30;
    drive(2, 10, 1);
    hold(1'b0, 3);
    hold(1'b1, 2);
    hold(1'b0, 3);
    drive(2, 10, 2);
    settle();
`ifdef PWM_GLITCH_FILTER_EN
    chk("t6 min period", min_per, 10);
`else
    chk("t6 min period", min_per, 5);
`endif

    // random segments
    for (int s = 0; s < 30; s++) begin
      int per;
      int hi;
      per = $urandom_range(2, 24);
      hi  = $urandom_range(1, per - 1);
      drive(hi, per, $urandom_range(1, 4));
      if ($urandom_range(0, 5) == 0) begin
        hold(1'($urandom_range(0, 1)), $urandom_range(5, TIMEOUT + 20));
      end
    end
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
